// File: rtl/reduce_gate_sweep.sv
// Registered WIDTH-input reduction gate (AND/OR/XOR/NAND/NOR/XNOR) with an exhaustive sweep engine.
// Latency: 1 cycle from operand acceptance (stream or sweep) to out_valid.
// Backpressure: one-entry result slot; in_ready and sweep advance only when the slot is free.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   mode[2:0]             0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved
//   in_valid/in_ready     operand stream handshake, in_data[WIDTH-1:0] operand
//   sweep_start           one-cycle request to apply all 2^WIDTH vectors in order
//   out_valid/out_ready   result handshake; out_data echoes the operand
//   out_y, out_err        gate result and reserved-mode flag
//   busy, sweep_done      sweep in progress, one-cycle end-of-sweep pulse
//
// WIDTH is meant to be used in the range 2..16.
module reduce_gate_sweep #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sweep_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_y,
  output logic             out_err,
  output logic             busy,
  output logic             sweep_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Gate evaluation, returns {err, y}. Reserved modes force y low.
  function automatic logic [1:0] gate_eval(input logic [2:0] m, input logic [WIDTH-1:0] v);
    logic [1:0] r;
    case (m)
      3'd0:    r = {1'b0, &v};
      3'd1:    r = {1'b0, |v};
      3'd2:    r = {1'b0, ^v};
      3'd3:    r = {1'b0, ~&v};
      3'd4:    r = {1'b0, ~|v};
      3'd5:    r = {1'b0, ~^v};
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_y_q, out_y_d;
  logic             out_err_q, out_err_d;
  logic             busy_q, busy_d;
  logic             sweep_done_q, sweep_done_d;

  logic             slot_free;
  logic             stream_load;
  logic             sweep_load;
  logic             last_vec;
  logic [WIDTH-1:0] ld_vec;
  logic [2:0]       ld_mode;
  logic [1:0]       ld_res;

  // The slot can take a new result when empty or when its current one leaves this cycle.
  assign slot_free   = !out_valid_q || out_ready;
  // sweep_start wins over a coincident operand, so the operand is not consumed.
  assign in_ready    = (state_q == S_IDLE) && !sweep_start && slot_free;
  assign stream_load = in_valid && in_ready;
  assign sweep_load  = (state_q == S_SWEEP) && slot_free;
  // Counter is one bit wider than the vector, so compare against the zero-extended all-ones value.
  assign last_vec    = (cnt_q == {1'b0, {WIDTH{1'b1}}});

  // Sweep operands use the mode latched at start, not the live mode input.
  assign ld_vec  = sweep_load ? cnt_q[WIDTH-1:0] : in_data;
  assign ld_mode = sweep_load ? mode_q : mode;
  assign ld_res  = gate_eval(ld_mode, ld_vec);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_y_d     = out_y_q;
    out_err_d   = out_err_q;

    // Result slot: a load overrides the drain; otherwise a taken result empties it.
    // Payload is left untouched unless loaded, so it stays stable while stalled.
    if (stream_load || sweep_load) begin
      out_valid_d = 1'b1;
      out_data_d  = ld_vec;
      out_y_d     = ld_res[0];
      out_err_d   = ld_res[1];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          mode_d  = mode;
          cnt_d   = '0;
          state_d = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (slot_free) begin
          cnt_d = cnt_q + {{WIDTH{1'b0}}, 1'b1};
          if (last_vec) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // The last sweep result is the only one that can be in the slot here.
        if (out_valid_q && out_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state.
    busy_d       = (state_d != S_IDLE);
    sweep_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mode_q       <= 3'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_y_q      <= 1'b0;
      out_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_y_q      <= out_y_d;
      out_err_q    <= out_err_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_y      = out_y_q;
  assign out_err    = out_err_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_reduce_gate_sweep.sv
module tb_reduce_gate_sweep;

  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic [2:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         sweep_start;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_y;
  logic         out_err;
  logic         busy;
  logic         sweep_done;

  reduce_gate_sweep #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sweep_start(sweep_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_y(out_y), .out_err(out_err), .busy(busy), .sweep_done(sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]   mode;
    logic [W-1:0] data;
    logic         y;
    logic         err;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic         y;
    logic         err;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   xfers = 0;
  int   dones = 0;
  int   last_xfer_cyc = 0;
  int   done_cyc = 0;
  logic stall_prev = 1'b0;
  logic [W+1:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: gate result from the number of ones in the operand.
  function automatic res_t model(input logic [2:0] m, input logic [W-1:0] d);
    res_t r;
    int   ones;
    ones  = $countones(d);
    r.data = d;
    r.err  = 1'b0;
    case (m)
      3'd0:    r.y = (ones == W);
      3'd1:    r.y = (ones > 0);
      3'd2:    r.y = (ones % 2 == 1);
      3'd3:    r.y = (ones != W);
      3'd4:    r.y = (ones == 0);
      3'd5:    r.y = (ones % 2 == 0);
      default: begin r.y = 1'b0; r.err = 1'b1; end
    endcase
    return r;
  endfunction

  // Called just after a falling edge with inputs already applied; observes
  // the handshakes that the next rising edge will act on, then advances.
  task automatic tick();
    res_t e;
    #1;
    if (sweep_done) begin dones++; done_cyc = cyc; end
    if (stall_prev)
      check("stall_hold", 32'({out_valid, out_data, out_y, out_err}), 32'({1'b1, held}));
    stall_prev = out_valid && !out_ready;
    held = {out_data, out_y, out_err};
    if (out_valid && out_ready) begin
      xfers++;
      last_xfer_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL spurious_result: got data %0h, expected no result", out_data);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'({out_data, out_y, out_err}), 32'({e.data, e.y, e.err}));
      end
    end
    if (in_valid && in_ready) exp_q.push_back(model(mode, in_data));
    @(negedge clk);
    cyc++;
  endtask

  task automatic push_sweep(input logic [2:0] m);
    for (int i = 0; i < (1 << W); i++) exp_q.push_back(model(m, W'(i)));
  endtask

  vec_t tbl[15];
  logic pat[4];

  initial begin
    tbl[0]  = '{3'd2, 3'b101, 1'b0, 1'b0};
    tbl[1]  = '{3'd2, 3'b111, 1'b1, 1'b0};
    tbl[2]  = '{3'd0, 3'b111, 1'b1, 1'b0};
    tbl[3]  = '{3'd0, 3'b110, 1'b0, 1'b0};
    tbl[4]  = '{3'd1, 3'b000, 1'b0, 1'b0};
    tbl[5]  = '{3'd1, 3'b100, 1'b1, 1'b0};
    tbl[6]  = '{3'd3, 3'b111, 1'b0, 1'b0};
    tbl[7]  = '{3'd3, 3'b011, 1'b1, 1'b0};
    tbl[8]  = '{3'd4, 3'b000, 1'b1, 1'b0};
    tbl[9]  = '{3'd4, 3'b010, 1'b0, 1'b0};
    tbl[10] = '{3'd5, 3'b101, 1'b1, 1'b0};
    tbl[11] = '{3'd5, 3'b100, 1'b0, 1'b0};
    tbl[12] = '{3'd6, 3'b111, 1'b0, 1'b1};
    tbl[13] = '{3'd3, 3'b111, 1'b0, 1'b0};
    tbl[14] = '{3'd7, 3'b000, 1'b0, 1'b1};
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    rst = 1'b1; mode = 3'd0; in_valid = 1'b0; in_data = '0;
    sweep_start = 1'b0; out_ready = 1'b1;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_y", 32'(out_y), 32'(0));
    check("rst_out_err", 32'(out_err), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_sweep_done", 32'(sweep_done), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back stream operands from the table, each visible one cycle later.
    for (int i = 0; i < 15; i++) begin
      mode = tbl[i].mode; in_data = tbl[i].data; in_valid = 1'b1;
      #1 check("stream_in_ready", 32'(in_ready), 32'(1));
      tick();
      check("stream_valid", 32'(out_valid), 32'(1));
      check("stream_data", 32'(out_data), 32'(tbl[i].data));
      check("stream_y", 32'(out_y), 32'(tbl[i].y));
      check("stream_err", 32'(out_err), 32'(tbl[i].err));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", 32'(exp_q.size()), 32'(0));

    // Sweep, AND, free-running consumer; coincident operand must be refused.
    xfers = 0; dones = 0;
    mode = 3'd0; sweep_start = 1'b1; in_valid = 1'b1; in_data = 3'b101;
    #1 check("start_blocks_in_ready", 32'(in_ready), 32'(0));
    push_sweep(3'd0);
    tick();
    sweep_start = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 40 && dones == 0; k++) begin
      check("busy_during_sweep", 32'(busy), 32'(1));
      tick();
    end
    check("sweep1_done_count", 32'(dones), 32'(1));
    check("sweep1_results", 32'(xfers), 32'(8));
    check("sweep1_done_timing", 32'(done_cyc - last_xfer_cyc), 32'(1));
    check("sweep1_queue", 32'(exp_q.size()), 32'(0));
    check("sweep1_busy_low", 32'(busy), 32'(0));
    tick(); tick();
    check("sweep1_single_pulse", 32'(dones), 32'(1));

    // Sweep, OR, stalled consumer, mode change and ignored restart mid-sweep.
    xfers = 0; dones = 0;
    mode = 3'd1; sweep_start = 1'b1;
    push_sweep(3'd1);
    tick();
    for (int k = 0; k < 80 && dones == 0; k++) begin
      out_ready = pat[k % 4];
      sweep_start = (k == 5);
      mode = 3'd5;
      tick();
    end
    sweep_start = 1'b0; out_ready = 1'b1;
    check("sweep2_done_count", 32'(dones), 32'(1));
    check("sweep2_results", 32'(xfers), 32'(8));
    check("sweep2_queue", 32'(exp_q.size()), 32'(0));
    tick(); tick();
    check("sweep2_no_restart", 32'(busy), 32'(0));

    // Sweep, XOR, random consumer.
    xfers = 0; dones = 0;
    mode = 3'd2; sweep_start = 1'b1;
    push_sweep(3'd2);
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k < 200 && dones == 0; k++) begin
      out_ready = 1'($urandom_range(1, 0));
      tick();
    end
    out_ready = 1'b1;
    check("sweep3_done_count", 32'(dones), 32'(1));
    check("sweep3_results", 32'(xfers), 32'(8));

    // Reset after the 4th sweep result.
    xfers = 0; dones = 0;
    mode = 3'd0; sweep_start = 1'b1;
    push_sweep(3'd0);
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k < 40 && xfers < 4; k++) tick();
    check("pre_reset_results", 32'(xfers), 32'(4));
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'(0));
    check("arst_out_data", 32'(out_data), 32'(0));
    check("arst_out_y", 32'(out_y), 32'(0));
    check("arst_out_err", 32'(out_err), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_sweep_done", 32'(sweep_done), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    stall_prev = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    check("arst_no_done", 32'(dones), 32'(0));
    check("arst_no_results", 32'(xfers), 32'(4));
    mode = 3'd4; in_data = 3'b000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_valid", 32'(out_valid), 32'(1));
    check("post_rst_nor", 32'(out_y), 32'(1));
    tick();

    // Random stream traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom_range(1, 0));
      mode      = 3'($urandom_range(7, 0));
      in_data   = W'($urandom_range(7, 0));
      out_ready = ($urandom_range(3, 0) != 0);
      #1 check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("random_drained", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
